// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide sequencer that owns the HI/LO pair.
//
// Runs MULT/MULTU as a WIDTH-step shift-add and DIV/DIVU as a WIDTH-step
// restoring divide on operand magnitudes. A final FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   start  - operation request, only honoured in IDLE
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   v1     - rs operand (multiplicand / dividend / MTHI-MTLO data)
//   v2     - rt operand (multiplier / divisor)
//   cancel - pipeline flush, aborts the in-flight operation
//   busy   - high while an operation is in CALC or FIX
//   done   - one-cycle pulse coinciding with the new HI/LO values
//   hi, lo - architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] v1,
  input  logic [WIDTH-1:0] v2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state;
  state_t state_next;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = v;
    return -s;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] s;
    s = v;
    return -s;
  endfunction

  // The most negative value maps to itself, which is the correct unsigned
  // magnitude for the datapath.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             use_sign);
    return (use_sign && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  // Operation context latched at start.
  logic             is_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             div_zero;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] opnd_b;
  logic [CNT_W-1:0] cnt;

  // acc_hi is the upper product half (top bit stays 0) or the partial
  // remainder; acc_lo is the multiplier being shifted out or the
  // dividend/quotient shift register.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             sign_op;
  logic             md_op;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign sign_op = ~op[0];
  assign md_op   = ~op[2];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start && !cancel && md_op) state_next = CALC;
      CALC: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_b});
    div_diff  = div_shift - {1'b0, opnd_b};

    prod_fix = {acc_hi[WIDTH-1:0], acc_lo};
    if (sgn_a ^ sgn_b) prod_fix = neg_2w(prod_fix);

    quo_fix = acc_lo;
    rem_fix = acc_hi[WIDTH-1:0];
    if (sgn_a ^ sgn_b) quo_fix = neg_w(quo_fix);
    if (sgn_a) rem_fix = neg_w(rem_fix);
    // Divide by zero returns the raw dividend and an all-ones quotient,
    // bypassing sign correction.
    if (div_zero) begin
      quo_fix = '1;
      rem_fix = raw_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
      opnd_b   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // Accept: latch magnitudes and sign flags, or service MTHI/MTLO.
        IDLE: begin
          if (start && !cancel) begin
            if (md_op) begin
              is_div   <= op[1];
              sgn_a    <= sign_op & v1[WIDTH-1];
              sgn_b    <= sign_op & v2[WIDTH-1];
              div_zero <= op[1] && (v2 == '0);
              raw_a    <= v1;
              acc_hi   <= '0;
              cnt      <= '0;
              if (op[1]) begin
                opnd_b <= magnitude(v2, sign_op);
                acc_lo <= magnitude(v1, sign_op);
              end else begin
                opnd_b <= magnitude(v1, sign_op);
                acc_lo <= magnitude(v2, sign_op);
              end
            end else if (op == OP_MTHI) begin
              hi <= v1;
            end else if (op == OP_MTLO) begin
              lo <= v1;
            end
          end
        end
        // Iterate: one product or quotient bit per cycle.
        CALC: begin
          if (!cancel) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              acc_hi <= div_ge ? div_diff : div_shift;
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= {1'b0, mul_sum[WIDTH:1]};
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        // Fix-up: sign-correct and commit, unless flushed this cycle.
        FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, modelled random
// operations, MTHI/MTLO, cancel in CALC and FIX, and async reset mid-operation.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] v1;
  logic [WIDTH-1:0] v2;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .v1(v1), .v2(v2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } res_t;
  res_t sb_q[$];

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] eh;
    logic [WIDTH-1:0] el;
  } vec_t;
  vec_t vecs[13];

  // Bench-side view of the architectural HI/LO.
  logic [WIDTH-1:0] model_hi = '0;
  logic [WIDTH-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                        input bit mid_start, input string tag);
    res_t r;
    int   busy_cnt;
    bit   seen;
    @(negedge clk);
    start = 1'b1; op = o; v1 = a; v2 = b;
    r.hi = eh; r.lo = el;
    sb_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (mid_start && i == 5) begin
        start = 1'b1; op = 3'b011; v1 = 32'h0000_0055; v2 = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done_seen"}, seen, 1);
    if (seen) begin
      check({tag, " busy_cycles"}, busy_cnt, WIDTH + 1);
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: got done with empty scoreboard, expected none", tag);
      end else begin
        r = sb_q.pop_front();
        check({tag, " hi"}, hi, r.hi);
        check({tag, " lo"}, lo, r.lo);
        model_hi = r.hi;
        model_lo = r.lo;
      end
      @(negedge clk);
      check({tag, " done_pulse"}, done, 0);
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [63:0]      p;
    longint           sp;
    int               sa;
    int               sbv;
    bit               flag;
    bit               found;
    int               cnt;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'b000; v1 = '0; v2 = '0;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{3'b011, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003};
    vecs[5]  = '{3'b011, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{3'b010, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{3'b000, 32'h7FFF_FFFF, 32'd2,        32'h0000_0000, 32'hFFFF_FFFE};
    vecs[11] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[12] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 1'b0,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      unique case (i % 4)
        0: begin
          p = {32'b0, a} * {32'b0, b};
          run_op(3'b001, a, b, p[63:32], p[31:0], 1'b0, $sformatf("rnd_multu%0d", i));
        end
        1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          p = sp;
          run_op(3'b000, a, b, p[63:32], p[31:0], 1'b0, $sformatf("rnd_mult%0d", i));
        end
        2: begin
          b = b >> (i * 3);
          if (b == 0) b = 32'd1;
          run_op(3'b011, a, b, a % b, a / b, 1'b0, $sformatf("rnd_divu%0d", i));
        end
        default: begin
          b = b >> (i * 2);
          if (b == 0) b = 32'd3;
          if (i[0]) b = -b;
          sa = $signed(a);
          sbv = $signed(b);
          if (sa == 32'sh8000_0000 && sbv == -1) begin
            b = 32'd3;
            sbv = 3;
          end
          run_op(3'b010, a, b, sa % sbv, sa / sbv, 1'b0, $sformatf("rnd_div%0d", i));
        end
      endcase
    end

    // MTHI / MTLO and no-op handling.
    @(negedge clk);
    start = 1'b1; op = 3'b100; v1 = 32'h0000_AAAA;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", hi, 32'h0000_AAAA);
    check("mthi lo", lo, model_lo);
    check("mthi busy", busy, 0);
    check("mthi done", done, 0);
    start = 1'b1; op = 3'b101; v1 = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h0000_5555);
    check("mtlo hi", hi, 32'h0000_AAAA);
    start = 1'b1; op = 3'b110; v1 = 32'h1111_1111;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    check("noop busy", busy, 0);
    check("noop hi", hi, 32'h0000_AAAA);
    check("noop lo", lo, 32'h0000_5555);
    start = 1'b1; cancel = 1'b1; op = 3'b101; v1 = 32'h0000_0001;
    @(negedge clk);
    op = 3'b001;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel lo", lo, 32'h0000_5555);
    check("idle_cancel busy", busy, 0);

    // Cancel in CALC, with a stray start mid-operation.
    start = 1'b1; op = 3'b001; v1 = 32'd2; v2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 3'b011; v1 = 32'd9; v2 = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("cancel_calc busy_before", busy, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_calc busy", busy, 0);
    check("cancel_calc done", done, 0);
    flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) flag = 1'b1;
    end
    check("cancel_calc quiet", flag, 0);
    check("cancel_calc hi", hi, 32'h0000_AAAA);
    check("cancel_calc lo", lo, 32'h0000_5555);

    // Cancel during FIX must suppress the write and done.
    start = 1'b1; op = 3'b001; v1 = 32'd2; v2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (busy) cnt++;
      if (cnt == WIDTH + 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cancel_fix reached", found, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_fix done", done, 0);
    check("cancel_fix busy", busy, 0);
    check("cancel_fix hi", hi, 32'h0000_AAAA);
    check("cancel_fix lo", lo, 32'h0000_5555);
    flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) flag = 1'b1;
    end
    check("cancel_fix no_late_done", flag, 0);

    // Asynchronous reset between edges mid-CALC.
    start = 1'b1; op = 3'b001; v1 = 32'd5; v2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset busy", busy, 0);
    check("async_reset done", done, 0);
    check("async_reset hi", hi, 0);
    check("async_reset lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "post_reset_multu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers.
- The single-cycle ALU cannot cover these operations, so this block runs a 32-step shift-add / restoring-divide datapath under an FSM.
- Asserts busy so hazard logic stalls any MFHI/MFLO or new mult/div until done.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request, sampled on the clock edge; accepted only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is a no-op.
- v1  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- v2  in  WIDTH  rt operand (multiplier / divisor).
- cancel  in  1  pipeline flush: aborts the in-flight operation.
- busy  out  1  high while in CALC or FIX.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and internal accumulators cleared. Reset mid-operation discards that operation.
- States: IDLE, CALC, FIX.
- IDLE, start=1, cancel=0, op in {MULT, MULTU, DIV, DIVU}:
  - Latch operand magnitudes. Signed ops take |v| (two's complement negate if MSB set); unsigned ops use v as-is.
  - Latch sign flags.
  - Clear the counter; go to CALC.
- IDLE, start=1, cancel=0, op=MTHI or MTLO: hi (or lo) := v1 at that edge. Stay in IDLE; no busy, no done.
- IDLE, op = 11x or cancel=1: no effect.
- CALC: one iteration per cycle; counter runs 0..WIDTH-1. After the WIDTH-th iteration, go to FIX.
  - Multiply: 2*WIDTH-bit unsigned shift-add product.
  - Divide: restoring, 1 quotient bit per cycle. The partial remainder is WIDTH+1 bits wide.
- FIX: apply sign correction, then write hi/lo. Next state IDLE; done=1 for exactly that next cycle.
  - Multiply: product negated if s1^s2 (signed ops only). {hi,lo} := product.
  - Divide: quotient negated if s1^s2; remainder negated if s1 (signed only). lo := quotient, hi := remainder.
- Timing: start sampled at edge E0.
  - busy=1 after E0 through the cycle following E(WIDTH); that is 33 cycles for WIDTH=32.
  - At E(WIDTH+1): hi/lo updated, busy=0, done=1.
  - Total latency from the start edge to done: WIDTH+1 edges.
- start while busy: ignored, with no queuing. The in-flight operation is unaffected.
- cancel=1 in CALC or FIX: next state IDLE; hi/lo unchanged; done stays 0. cancel has priority over a same-cycle FIX write.
- Divide by zero: no exception. lo := all ones, hi := v1 (raw dividend), for signed and unsigned ops alike; sign correction is skipped.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- hi/lo change only on a FIX write, MTHI/MTLO, or reset.

Test Plan:
- MULT v1=0xFFFFFFFD (-3), v2=5 -> done after 33 busy cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU v1=v2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT on the same operands -> hi=0, lo=1.
- DIV v1=0xFFFFFFF9 (-7), v2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU v1=7, v2=2 -> lo=3, hi=1.
- DIVU v1=0x1234, v2=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- After MTHI 0xAAAA, start MULTU 2*3; at cycle 10 assert cancel; also pulse start mid-op with a different operation -> busy drops the next cycle, no done, hi=0xAAAA, and the second start has no effect.
- Assert async reset mid-CALC (between edges) -> busy/done/hi/lo=0 immediately. A fresh MULTU 6*7 afterwards yields lo=42, hi=0.
